// File: rtl/unidade_pc.sv
// Fetch-stage program counter: increment, stall, branch, single-level trap entry/return.
// Optional feature macro PC_ALIGN_CHECK_EN turns misaligned branch targets into a trap.
module unidade_pc #(
  parameter int unsigned      WIDTH        = 64,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             trap,
  input  logic             trap_return,
  output logic [WIDTH-1:0] endereco,
  output logic [WIDTH-1:0] epc,
  output logic             in_trap,
  output logic             flush,
  output logic             misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] epc_next;
  logic             flush_next;
  logic             trap_accept;
  logic             return_accept;

  // trap only enters from RUN, trap_return only leaves from TRAP; otherwise they fall through
  assign trap_accept   = trap && (state == RUN);
  assign return_accept = trap_return && (state == TRAP);
  assign in_trap       = (state == TRAP);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  logic target_misaligned;
  logic misalign_next;
  logic misalign_q;

  assign target_misaligned = |(branch_target & ALIGN_MASK);
  assign misalign          = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = endereco + STEP;
    epc_next   = epc;
    flush_next = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_next = 1'b0;
`endif
    if (trap_accept) begin
      state_next = TRAP;
      pc_next    = TRAP_VECTOR;
      epc_next   = endereco;
      flush_next = 1'b1;
    end else if (return_accept) begin
      state_next = RUN;
      pc_next    = epc;
      flush_next = 1'b1;
    end else if (branch_en) begin
`ifdef PC_ALIGN_CHECK_EN
      if (target_misaligned) begin
        misalign_next = 1'b1;
        if (state == RUN) begin
          state_next = TRAP;
          pc_next    = TRAP_VECTOR;
          epc_next   = endereco;
          flush_next = 1'b1;
        end else begin
          // already in the handler: no nesting, just hold and report
          pc_next = endereco;
        end
      end else begin
        pc_next    = branch_target;
        flush_next = 1'b1;
      end
`else
      pc_next    = branch_target;
      flush_next = 1'b1;
`endif
    end else if (stall) begin
      pc_next = endereco;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      endereco <= RESET_VECTOR;
      epc      <= '0;
      flush    <= 1'b0;
    end else begin
      state    <= state_next;
      endereco <= pc_next;
      epc      <= epc_next;
      flush    <= flush_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_next;
    end
  end
`endif

endmodule

// File: tb/tb_unidade_pc.sv
// Directed bench for unidade_pc: a 64-bit instance for the main behaviour and an
// 8-bit instance for address wrap; expectations go through a scoreboard queue.
module tb_unidade_pc;

  localparam int EW = 131;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // wide instance
  logic        stall = 1'b0, branch_en = 1'b0, trap = 1'b0, trap_return = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] endereco, epc;
  logic        in_trap, flush, misalign;

  // narrow instance
  logic       n_stall = 1'b0, n_branch_en = 1'b0, n_trap = 1'b0, n_trap_return = 1'b0;
  logic [7:0] n_branch_target = '0;
  logic [7:0] n_endereco, n_epc;
  logic       n_in_trap, n_flush, n_misalign;

  unidade_pc dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .trap(trap), .trap_return(trap_return),
    .endereco(endereco), .epc(epc), .in_trap(in_trap), .flush(flush), .misalign(misalign)
  );

  unidade_pc #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) dut_n (
    .clock(clock), .reset(reset), .stall(n_stall), .branch_en(n_branch_en),
    .branch_target(n_branch_target), .trap(n_trap), .trap_return(n_trap_return),
    .endereco(n_endereco), .epc(n_epc), .in_trap(n_in_trap), .flush(n_flush),
    .misalign(n_misalign)
  );

  // scoreboard: {pc[64], epc[64], in_trap, flush, misalign}
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string name, input logic [63:0] o_pc, input logic [63:0] o_epc,
                         input logic o_it, input logic o_fl, input logic o_mis);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".pc"},       o_pc,          e[130:67]);
      check({name, ".epc"},      o_epc,         e[66:3]);
      check({name, ".in_trap"},  64'(o_it),     64'(e[2]));
      check({name, ".flush"},    64'(o_fl),     64'(e[1]));
      check({name, ".misalign"}, 64'(o_mis),    64'(e[0]));
    end
  endtask

  // driver: set inputs on the falling edge, check #1 after the next rising edge
  task automatic step(input string name, input logic st, input logic br, input logic [63:0] tgt,
                      input logic tr, input logic rt, input logic [63:0] e_pc,
                      input logic [63:0] e_epc, input logic e_it, input logic e_fl,
                      input logic e_mis);
    @(negedge clock);
    stall = st; branch_en = br; branch_target = tgt; trap = tr; trap_return = rt;
    exp_q.push_back({e_pc, e_epc, e_it, e_fl, e_mis});
    @(posedge clock);
    #1;
    compare(name, endereco, epc, in_trap, flush, misalign);
    stall = 1'b0; branch_en = 1'b0; trap = 1'b0; trap_return = 1'b0;
  endtask

  task automatic step_n(input string name, input logic br, input logic [7:0] tgt,
                        input logic [7:0] e_pc, input logic e_fl);
    @(negedge clock);
    n_branch_en = br; n_branch_target = tgt;
    exp_q.push_back({56'd0, e_pc, 64'd0, 1'b0, e_fl, 1'b0});
    @(posedge clock);
    #1;
    compare(name, {56'd0, n_endereco}, {56'd0, n_epc}, n_in_trap, n_flush, n_misalign);
    n_branch_en = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, ".pc"},      endereco,       64'h0);
    check({name, ".epc"},     epc,            64'h0);
    check({name, ".in_trap"}, 64'(in_trap),   64'h0);
    check({name, ".flush"},   64'(flush),     64'h0);
    check({name, ".misalign"},64'(misalign),  64'h0);
    check({name, ".n_pc"},    64'(n_endereco),64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    check_reset_values("rst0");
    reset = 1'b0;

    //   name   st br tgt     tr rt  pc      epc    it fl mis
    step("inc1", 0, 0, 64'h0,   0, 0, 64'h4,   64'h0, 0, 0, 0);
    step("inc2", 0, 0, 64'h0,   0, 0, 64'h8,   64'h0, 0, 0, 0);
    step("stl1", 1, 0, 64'h0,   0, 0, 64'h8,   64'h0, 0, 0, 0);
    step("stl2", 1, 0, 64'h0,   0, 0, 64'h8,   64'h0, 0, 0, 0);
    step("stbr", 1, 1, 64'h40,  0, 0, 64'h40,  64'h0, 0, 1, 0);
    step("inc3", 0, 0, 64'h0,   0, 0, 64'h44,  64'h0, 0, 0, 0);
    step("br20", 0, 1, 64'h20,  0, 0, 64'h20,  64'h0, 0, 1, 0);
    step("trp1", 0, 0, 64'h0,   1, 0, 64'h100, 64'h20, 1, 1, 0);
    step("hnd1", 0, 0, 64'h0,   0, 0, 64'h104, 64'h20, 1, 0, 0);
    step("hnd2", 0, 0, 64'h0,   0, 0, 64'h108, 64'h20, 1, 0, 0);
    step("nest", 0, 0, 64'h0,   1, 0, 64'h10C, 64'h20, 1, 0, 0);
    step("ret1", 0, 0, 64'h0,   0, 1, 64'h20,  64'h20, 0, 1, 0);
    step("sret", 0, 1, 64'h80,  0, 1, 64'h80,  64'h20, 0, 1, 0);
    step("srst", 1, 0, 64'h0,   0, 1, 64'h80,  64'h20, 0, 0, 0);
    step("br10", 0, 1, 64'h10,  0, 0, 64'h10,  64'h20, 0, 1, 0);
    step("trbr", 1, 1, 64'h200, 1, 0, 64'h100, 64'h10, 1, 1, 0);
    step("rtbr", 0, 1, 64'h300, 0, 1, 64'h10,  64'h10, 0, 1, 0);
    step("trp2", 0, 0, 64'h0,   1, 0, 64'h100, 64'h10, 1, 1, 0);

    // asynchronous reset in the middle of the handler
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rsta");
    @(posedge clock);
    #1;
    check_reset_values("rsth");
    reset = 1'b0;

    step("inc4", 0, 0, 64'h0,   0, 0, 64'h4,   64'h0, 0, 0, 0);
    step("inc5", 0, 0, 64'h0,   0, 0, 64'h8,   64'h0, 0, 0, 0);
    step("br30", 0, 1, 64'h30,  0, 0, 64'h30,  64'h0, 0, 1, 0);
`ifdef PC_ALIGN_CHECK_EN
    step("mis1", 0, 1, 64'h42,  0, 0, 64'h100, 64'h30, 1, 1, 1);
    step("mis2", 0, 0, 64'h0,   0, 0, 64'h104, 64'h30, 1, 0, 0);
    step("mis3", 0, 1, 64'h42,  0, 0, 64'h104, 64'h30, 1, 0, 1);
    step("mis4", 0, 0, 64'h0,   0, 0, 64'h108, 64'h30, 1, 0, 0);
`else
    step("mis1", 0, 1, 64'h42,  0, 0, 64'h42,  64'h0, 0, 1, 0);
    step("mis2", 0, 0, 64'h0,   0, 0, 64'h46,  64'h0, 0, 0, 0);
    step("mis3", 0, 1, 64'h42,  0, 0, 64'h42,  64'h0, 0, 1, 0);
    step("mis4", 0, 0, 64'h0,   0, 0, 64'h46,  64'h0, 0, 0, 0);
`endif

    // 8-bit address wrap
    step_n("nbr",  1, 8'hF8, 8'hF8, 1);
    step_n("ninc", 0, 8'h00, 8'hFC, 0);
    step_n("nwrp", 0, 8'h00, 8'h00, 0);
    step_n("npst", 0, 8'h00, 8'h04, 0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
